sram_responder: RTL and testbench
=================================

# sram_responder

Synthesizable single-clock emulator of the asynchronous 8-bit SRAM device that `sram_arbiter` drives. It answers the `sram_ce_n`/`sram_oe_n`/`sram_we_n`/`sram_addr` bus from a block-RAM array, using a configurable read latency. It sits in place of the external chip for on-chip loopback builds and simulation benches. It flags protocol violations and keeps access counts.

## Interface
Parameters:
- `AW`, 19: address width; array depth is 2**AW words.
- `DW`, 8: data width.
- `RD_LAT`, 1: read latency in clocks, legal range 1–8.

Ports:
- `clk` in 1: system clock, single clock domain.
- `rst` in 1: reset, asynchronous and active-high.
- `sram_addr` in AW: word address.
- `sram_ce_n` in 1: chip enable, active-low.
- `sram_oe_n` in 1: output enable, active-low.
- `sram_we_n` in 1: write enable, active-low.
- `sram_dq_wr` in DW: write data driven by the initiator.
- `sram_dq_rd` out DW: read data returned to the initiator.
- `sram_dq_oe` out 1: high while the responder owns the data bus; drives the top-level tristate.
- `err_clear` in 1: clears both sticky error flags.
- `err_contention` out 1: sticky; `oe_n` and `we_n` were both low while selected.
- `err_busfight` out 1: sticky; the initiator wrote while `sram_dq_oe` was high.
- `wr_count` out 32: completed writes, saturating.
- `rd_count` out 32: issued reads, saturating.

## Operation
- All inputs are sampled on the rising `clk` edge. There is no input resynchronizer; the inputs are already synchronous to `clk`.
- The command is decoded at each edge when `ce_n`=0:
  - WRITE: `we_n`=0. `mem[sram_addr] <= sram_dq_wr`. `wr_count` increments.
  - READ: `we_n`=1 and `oe_n`=0. `mem[sram_addr]` enters the read pipeline and `rd_count` increments.
  - CONTENTION: `we_n`=0 and `oe_n`=0. WE dominates: the write is performed and counted, no read is issued, and `err_contention` is set.
  - `ce_n`=1, or `ce_n`=0 with `oe_n`=`we_n`=1: idle. No array access takes place.
- The read pipeline is RD_LAT stages, each holding a valid bit and data. It is fully pipelined, so one read can be issued per cycle with no bubbles.
- When the last stage is valid, `sram_dq_rd` takes that data and `sram_dq_oe`=1 for exactly one cycle.
- When the last stage is not valid, `sram_dq_oe`=0 and `sram_dq_rd` holds its previous value.
- Read data is the array content at the sampling edge:
  - A write at an earlier edge is visible.
  - A write at a later edge does not alter a read already in flight.
- `err_busfight` is set at any edge where `sram_dq_oe`=1 and a WRITE or CONTENTION command is sampled. The write still occurs.
- Error flags are sticky until `err_clear`=1 is sampled. If a set condition and `err_clear` occur on the same edge, set wins.
- Counters are 32-bit, saturate at 0xFFFF_FFFF, and are cleared only by reset.
- The array is not initialized and is not cleared by reset; contents survive `rst`.

## Timing
- Reset (asynchronous, on `rst` assertion):
  - `sram_dq_rd`=0, `sram_dq_oe`=0.
  - `err_contention`=0, `err_busfight`=0.
  - `wr_count`=0, `rd_count`=0.
  - All pipeline valid bits are 0.
- Release of reset is synchronous to `clk`. The first command is accepted at the first edge with `rst` low.
- Reset mid-operation discards all in-flight reads: `sram_dq_oe` falls immediately and no stale data appears after release. A write sampled at the same edge as reset assertion is not guaranteed.
- A READ sampled at edge E drives `sram_dq_rd`/`sram_dq_oe` from edge E+RD_LAT−1 until edge E+RD_LAT. With RD_LAT=1, data is valid in the cycle immediately after the command cycle, matching `sram_arbiter` with RD_LAT=1.
- A WRITE sampled at edge E is readable by a READ sampled at edge E+1 or later.
- `wr_count`/`rd_count` update at the same edge that samples the command.
- The error flags assert at the edge that detects the violation.

## Test plan
- Reset and write-then-read:
  - Stimulus: assert `rst` mid-cycle; write 0xA5 to addr 0x00010 at edge 1, then read addr 0x00010 at edge 2 (RD_LAT=1).
  - Required response: all outputs 0 asynchronously. After release, `sram_dq_rd`=0xA5 with `sram_dq_oe`=1 for exactly one cycle after edge 2; `wr_count`=1, `rd_count`=1.
- Ramp load and readback (AW=11, RD_LAT=3):
  - Stimulus: write `addr[10:3]` to all 2048 addresses, then issue back-to-back reads of all 2048 addresses.
  - Required response: data arrives 2 edges after each read, with `sram_dq_oe` high continuously for 2048 cycles; `wr_count`=`rd_count`=2048.
- Contention:
  - Stimulus: `ce_n`=0, `oe_n`=0, `we_n`=0, data 0x3C at addr 5; then a normal read of addr 5.
  - Required response: `err_contention`=1, no read issued from the contention cycle, and the following read returns 0x3C.
- Bus fight (RD_LAT=2):
  - Stimulus: read addr 1, then a write to addr 2 sampled while `sram_dq_oe`=1.
  - Required response: `err_busfight`=1 and addr 2 is updated.
  - Stimulus: `err_clear`=1 at the same edge as a new violation.
  - Required response: the flag stays 1.
- Reset mid-read (RD_LAT=3):
  - Stimulus: assert `rst` one cycle after a read is issued.
  - Required response: `sram_dq_oe` never pulses, counters are 0, and array contents are unchanged when read after release.
- Counter saturation:
  - Stimulus: force `wr_count` to 0xFFFF_FFFE, then perform 3 writes.
  - Required response: `wr_count`=0xFFFF_FFFF.

Source files
------------

// File: rtl/sram_responder.sv
// sram_responder: single-clock block-RAM stand-in for an asynchronous SRAM, with a
// fixed-latency read pipeline, sticky protocol-violation flags and saturating counters.
module sram_responder #(
   parameter int unsigned AW     = 19,
   parameter int unsigned DW     = 8,
   parameter int unsigned RD_LAT = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] sram_addr,
   input  logic          sram_ce_n,
   input  logic          sram_oe_n,
   input  logic          sram_we_n,
   input  logic [DW-1:0] sram_dq_wr,
   output logic [DW-1:0] sram_dq_rd,
   output logic          sram_dq_oe,
   input  logic          err_clear,
   output logic          err_contention,
   output logic          err_busfight,
   output logic [31:0]   wr_count,
   output logic [31:0]   rd_count
);

   logic [DW-1:0]     r_mem [2**AW];
   logic [RD_LAT-1:0] r_vld;
   logic [DW-1:0]     r_dat [RD_LAT];
   logic              r_err_cont;
   logic              r_err_fight;
   logic [31:0]       r_wr_cnt;
   logic [31:0]       r_rd_cnt;

   logic w_wr;
   logic w_rd;
   logic w_cont;

   // WE dominates OE: a contention cycle is a write and never issues a read
   assign w_wr   = ~sram_ce_n & ~sram_we_n;
   assign w_rd   = ~sram_ce_n &  sram_we_n & ~sram_oe_n;
   assign w_cont = w_wr & ~sram_oe_n;

   // Array has no reset so its contents survive rst
   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[sram_addr] <= sram_dq_wr;
      end
   end

   // Stage data only advances behind a valid bit, so the last stage holds between reads
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vld <= '0;
         for (int unsigned i = 0; i < RD_LAT; i++) begin
            r_dat[i] <= '0;
         end
      end else begin
         r_vld[0] <= w_rd;
         if (w_rd) begin
            r_dat[0] <= r_mem[sram_addr];
         end
         for (int unsigned i = 1; i < RD_LAT; i++) begin
            r_vld[i] <= r_vld[i-1];
            if (r_vld[i-1]) begin
               r_dat[i] <= r_dat[i-1];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err_cont  <= 1'b0;
         r_err_fight <= 1'b0;
         r_wr_cnt    <= '0;
         r_rd_cnt    <= '0;
      end else begin
         if (w_cont) begin
            r_err_cont <= 1'b1;
         end else if (err_clear) begin
            r_err_cont <= 1'b0;
         end
         if (w_wr && sram_dq_oe) begin
            r_err_fight <= 1'b1;
         end else if (err_clear) begin
            r_err_fight <= 1'b0;
         end
         if (w_wr && (r_wr_cnt != '1)) begin
            r_wr_cnt <= r_wr_cnt + 32'd1;
         end
         if (w_rd && (r_rd_cnt != '1)) begin
            r_rd_cnt <= r_rd_cnt + 32'd1;
         end
      end
   end

   assign sram_dq_oe     = r_vld[RD_LAT-1];
   assign sram_dq_rd     = r_dat[RD_LAT-1];
   assign err_contention = r_err_cont;
   assign err_busfight   = r_err_fight;
   assign wr_count       = r_wr_cnt;
   assign rd_count       = r_rd_cnt;

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: three instances (RD_LAT 1/2/3) share one stimulus stream and
// are checked against a command-history reference model plus directed vectors.
module tb_sram_responder;
   localparam int unsigned AW = 11;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [AW-1:0] addr = '0;
   logic          ce_n = 1'b1, oe_n = 1'b1, we_n = 1'b1;
   logic [7:0]    wd = '0;
   logic          clr = 1'b0;

   logic [7:0]  rd [3];
   logic        oe [3];
   logic        ec [3];
   logic        eb [3];
   logic [31:0] wc [3];
   logic [31:0] rc [3];

   always #5 clk = ~clk;

   sram_responder #(.AW(AW), .DW(8), .RD_LAT(1)) u_l1 (
      .clk(clk), .rst(rst), .sram_addr(addr), .sram_ce_n(ce_n), .sram_oe_n(oe_n),
      .sram_we_n(we_n), .sram_dq_wr(wd), .sram_dq_rd(rd[0]), .sram_dq_oe(oe[0]),
      .err_clear(clr), .err_contention(ec[0]), .err_busfight(eb[0]),
      .wr_count(wc[0]), .rd_count(rc[0]));
   sram_responder #(.AW(AW), .DW(8), .RD_LAT(2)) u_l2 (
      .clk(clk), .rst(rst), .sram_addr(addr), .sram_ce_n(ce_n), .sram_oe_n(oe_n),
      .sram_we_n(we_n), .sram_dq_wr(wd), .sram_dq_rd(rd[1]), .sram_dq_oe(oe[1]),
      .err_clear(clr), .err_contention(ec[1]), .err_busfight(eb[1]),
      .wr_count(wc[1]), .rd_count(rc[1]));
   sram_responder #(.AW(AW), .DW(8), .RD_LAT(3)) u_l3 (
      .clk(clk), .rst(rst), .sram_addr(addr), .sram_ce_n(ce_n), .sram_oe_n(oe_n),
      .sram_we_n(we_n), .sram_dq_wr(wd), .sram_dq_rd(rd[2]), .sram_dq_oe(oe[2]),
      .err_clear(clr), .err_contention(ec[2]), .err_busfight(eb[2]),
      .wr_count(wc[2]), .rd_count(rc[2]));

   // Reference model: array image, history of issued reads (index 0 = latest edge)
   logic [7:0]  m_mem [2**AW];
   logic        h_v [8];
   logic [7:0]  h_d [8];
   logic        m_oe [3];
   logic [7:0]  m_rd [3];
   logic        m_ec [3];
   logic        m_eb [3];
   logic [31:0] m_wc [3];
   logic [31:0] m_rc [3];

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   typedef struct {
      logic        ce_n, oe_n, we_n;
      logic [10:0] a;
      logic [7:0]  d;
      logic        x_oe;
      logic [7:0]  x_rd;
      logic [31:0] x_wc, x_rc;
   } vec_t;
   vec_t tv [10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic check_all(input string tag);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("%s L%0d dq_oe", tag, k + 1), 32'(oe[k]), 32'(m_oe[k]));
         chk($sformatf("%s L%0d dq_rd", tag, k + 1), 32'(rd[k]), 32'(m_rd[k]));
         chk($sformatf("%s L%0d err_cont", tag, k + 1), 32'(ec[k]), 32'(m_ec[k]));
         chk($sformatf("%s L%0d err_fight", tag, k + 1), 32'(eb[k]), 32'(m_eb[k]));
         chk($sformatf("%s L%0d wr_count", tag, k + 1), wc[k], m_wc[k]);
         chk($sformatf("%s L%0d rd_count", tag, k + 1), rc[k], m_rc[k]);
      end
   endtask

   task automatic model_reset();
      for (int j = 0; j < 8; j++) begin
         h_v[j] = 1'b0;
         h_d[j] = 8'h00;
      end
      for (int k = 0; k < 3; k++) begin
         m_oe[k] = 1'b0; m_rd[k] = 8'h00; m_ec[k] = 1'b0; m_eb[k] = 1'b0;
         m_wc[k] = 32'd0; m_rc[k] = 32'd0;
      end
   endtask

   task automatic drive(input logic c, input logic o, input logic w, input logic [10:0] a,
                        input logic [7:0] d, input logic cl);
      ce_n = c; oe_n = o; we_n = w; addr = a; wd = d; clr = cl;
   endtask

   // One clock: model the sampled command, then compare all instances
   task automatic step(input string tag);
      logic prev_oe [3];
      logic is_wr, is_rd, is_cont;
      for (int k = 0; k < 3; k++) prev_oe[k] = m_oe[k];
      @(posedge clk);
      is_wr   = !ce_n && !we_n;
      is_rd   = !ce_n && we_n && !oe_n;
      is_cont = is_wr && !oe_n;
      for (int j = 7; j > 0; j--) begin
         h_v[j] = h_v[j-1];
         h_d[j] = h_d[j-1];
      end
      h_v[0] = is_rd;
      h_d[0] = m_mem[addr];
      if (is_wr) m_mem[addr] = wd;
      for (int k = 0; k < 3; k++) begin
         if (is_wr && m_wc[k] != 32'hFFFF_FFFF) m_wc[k] = m_wc[k] + 1;
         if (is_rd && m_rc[k] != 32'hFFFF_FFFF) m_rc[k] = m_rc[k] + 1;
         if (is_cont) m_ec[k] = 1'b1;
         else if (clr) m_ec[k] = 1'b0;
         if (is_wr && prev_oe[k]) m_eb[k] = 1'b1;
         else if (clr) m_eb[k] = 1'b0;
         m_oe[k] = h_v[k];
         if (h_v[k]) m_rd[k] = h_d[k];
      end
      #1;
      check_all(tag);
      @(negedge clk);
   endtask

   task automatic do_reset();
      drive(1, 1, 1, '0, '0, 0);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_all("reset");
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #500us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int unsigned t, first, last, cnt, pulses;
      logic seen;
      logic [31:0] rc_save;

      tv[0] = '{0, 1, 0, 11'h010, 8'hA5, 0, 8'h00, 1, 0};
      tv[1] = '{0, 0, 1, 11'h010, 8'h00, 1, 8'hA5, 1, 1};
      tv[2] = '{1, 1, 1, 11'h000, 8'h00, 0, 8'hA5, 1, 1};
      tv[3] = '{0, 1, 0, 11'h011, 8'h5A, 0, 8'hA5, 2, 1};
      tv[4] = '{0, 0, 1, 11'h011, 8'h00, 1, 8'h5A, 2, 2};
      tv[5] = '{0, 0, 1, 11'h010, 8'h00, 1, 8'hA5, 2, 3};
      tv[6] = '{1, 0, 1, 11'h011, 8'h00, 0, 8'hA5, 2, 3};
      tv[7] = '{0, 1, 1, 11'h011, 8'h00, 0, 8'hA5, 2, 3};
      tv[8] = '{1, 1, 0, 11'h010, 8'hFF, 0, 8'hA5, 2, 3};
      tv[9] = '{0, 0, 1, 11'h010, 8'h00, 1, 8'hA5, 2, 4};

      for (int i = 0; i < 2**AW; i++) m_mem[i] = 8'h00;
      model_reset();
      @(negedge clk);
      do_reset();

      // Directed vectors against the RD_LAT=1 instance
      for (int i = 0; i < 10; i++) begin
         drive(tv[i].ce_n, tv[i].oe_n, tv[i].we_n, tv[i].a, tv[i].d, 0);
         step($sformatf("vec%0d", i));
         chk($sformatf("vec%0d table dq_oe", i), 32'(oe[0]), 32'(tv[i].x_oe));
         chk($sformatf("vec%0d table dq_rd", i), 32'(rd[0]), 32'(tv[i].x_rd));
         chk($sformatf("vec%0d table wr_count", i), wc[0], tv[i].x_wc);
         chk($sformatf("vec%0d table rd_count", i), rc[0], tv[i].x_rc);
      end

      // Ramp load then back-to-back readback
      do_reset();
      for (int i = 0; i < 2**AW; i++) begin
         drive(0, 1, 0, 11'(i), 8'(i >> 3), 0);
         step("ramp_wr");
      end
      t = 0; cnt = 0; first = 0; last = 0; seen = 1'b0;
      for (int i = 0; i < 2**AW + 3; i++) begin
         if (i < 2**AW) drive(0, 0, 1, 11'(i), 8'h00, 0);
         else drive(1, 1, 1, '0, '0, 0);
         step("ramp_rd");
         if (oe[2]) begin
            if (!seen) first = t;
            last = t;
            cnt++;
            seen = 1'b1;
         end
         t++;
      end
      chk("ramp L3 oe count", cnt, 2048);
      chk("ramp L3 oe span", last - first + 1, 2048);
      chk("ramp L3 first oe step", first, 2);
      chk("ramp L3 wr_count", wc[2], 2048);
      chk("ramp L3 rd_count", rc[2], 2048);

      // Contention: write wins, no read issued
      rc_save = rc[0];
      drive(0, 0, 0, 11'd5, 8'h3C, 0);
      step("cont");
      chk("cont L1 err_contention", 32'(ec[0]), 1);
      chk("cont L1 no read", rc[0], rc_save);
      drive(0, 0, 1, 11'd5, 8'h00, 0);
      step("cont_rd");
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 1, '0, '0, 0);
         step("cont_idle");
      end
      chk("cont L3 readback", 32'(rd[2]), 32'h3C);
      drive(1, 1, 1, '0, '0, 1);
      step("cont_clr");
      chk("cont L1 cleared", 32'(ec[0]), 0);

      // Bus fight with RD_LAT=2
      do_reset();
      drive(0, 0, 1, 11'd1, 8'h00, 0); step("bf_rd");
      drive(1, 1, 1, '0, '0, 0);       step("bf_idle");
      drive(0, 1, 0, 11'd2, 8'hC3, 0); step("bf_wr");
      chk("busfight L2 set", 32'(eb[1]), 1);
      chk("busfight L1 clean", 32'(eb[0]), 0);
      drive(0, 0, 1, 11'd2, 8'h00, 0); step("bf_rd2");
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 1, '0, '0, 0);
         step("bf_idle2");
      end
      chk("busfight L2 addr2 written", 32'(rd[1]), 32'hC3);
      drive(0, 0, 1, 11'd1, 8'h00, 0); step("bf_rd3");
      drive(1, 1, 1, '0, '0, 0);       step("bf_idle3");
      drive(0, 1, 0, 11'd3, 8'h99, 1); step("bf_wr_clr");
      chk("busfight L2 set beats clear", 32'(eb[1]), 1);

      // Reset while a read is in flight
      do_reset();
      drive(0, 1, 0, 11'd7, 8'h77, 0); step("rr_wr");
      drive(0, 0, 1, 11'd7, 8'h00, 0); step("rr_rd");
      drive(1, 1, 1, '0, '0, 0);       step("rr_idle");
      do_reset();
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         drive(1, 1, 1, '0, '0, 0);
         step("rr_post");
         if (oe[2]) pulses++;
      end
      chk("rst mid-read L3 no pulse", pulses, 0);
      chk("rst mid-read L3 rd_count", rc[2], 0);
      drive(0, 0, 1, 11'd7, 8'h00, 0); step("rr_rd2");
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 1, '0, '0, 0);
         step("rr_idle2");
      end
      chk("rst mid-read L3 contents kept", 32'(rd[2]), 32'h77);

      // Randomized traffic
      for (int i = 0; i < 800; i++) begin
         drive(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0),
               1'($urandom_range(0, 2) != 0), 11'($urandom), 8'($urandom),
               1'($urandom_range(0, 15) == 0));
         step("rand");
      end

      // Write counter saturation
      drive(1, 1, 1, '0, '0, 0);
      force u_l1.r_wr_cnt = 32'hFFFF_FFFE;
      #1;
      release u_l1.r_wr_cnt;
      m_wc[0] = 32'hFFFF_FFFE;
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 0, 11'(100 + i), 8'(i), 0);
         step("sat");
      end
      chk("saturate L1 wr_count", wc[0], 32'hFFFF_FFFF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
